// File: rtl/product_bcd_if.sv
// Handshake and result bundle for the product-to-BCD converter.
interface product_bcd_if;
    logic        Start;
    logic [15:0] Product_In;
    logic        Sign;
    logic [19:0] BCD;
    logic        Busy;
    logic        Done;

    modport master (output Start, output Product_In,
                    input Sign, input BCD, input Busy, input Done);
    modport slave  (input Start, input Product_In,
                    output Sign, output BCD, output Busy, output Done);
endinterface

// File: rtl/product_bcd.sv
// Converts a 16-bit multiplier product to sign plus five BCD digits using
// a 16-step double-dabble; results are held until the next conversion completes.
module product_bcd #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    product_bcd_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t      state;
    logic [15:0] mag;
    logic [19:0] digits;
    logic        pend_sign;
    logic [4:0]  iter;

    logic        neg_in;
    logic [15:0] cap_mag;
    logic [19:0] adj;
    logic [19:0] digits_next;
    logic [15:0] mag_next;

    // 0x8000 negates to itself, which is the correct unsigned magnitude 32768.
    always_comb begin
        neg_in  = SIGNED_IN && bus.Product_In[15];
        cap_mag = neg_in ? (~bus.Product_In + 16'd1) : bus.Product_In;
    end

    always_comb begin
        adj = digits;
        for (int i = 0; i < 5; i++) begin
            adj[4*i +: 4] = (digits[4*i +: 4] >= 4'd5) ? (digits[4*i +: 4] + 4'd3)
                                                       : digits[4*i +: 4];
        end
        digits_next = {adj[18:0], mag[15]};
        mag_next    = {mag[14:0], 1'b0};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            mag       <= '0;
            digits    <= '0;
            pend_sign <= 1'b0;
            iter      <= '0;
            bus.Sign  <= 1'b0;
            bus.BCD   <= '0;
            bus.Busy  <= 1'b0;
            bus.Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.Done <= 1'b0;
                    if (bus.Start) begin
                        mag       <= cap_mag;
                        pend_sign <= neg_in;
                        digits    <= '0;
                        iter      <= '0;
                        bus.Busy  <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    digits <= digits_next;
                    mag    <= mag_next;
                    iter   <= iter + 5'd1;
                    // The sixteenth shift publishes straight from the next-state value.
                    if (iter == 5'd15) begin
                        bus.BCD  <= digits_next;
                        bus.Sign <= pend_sign;
                        bus.Done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.Done <= 1'b0;
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.Done <= 1'b0;
                    bus.Busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
